// File: rtl/ps2_host_tx_if.sv
// Host-to-device PS/2 transmitter bus: byte request handshake, pad samples and open-drain enables, status.
// master = user/pad side, slave = ps2_host_tx.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       ack_err;

    modport master (
        output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        input  tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err
    );

    modport slave (
        input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        output tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, 8 data bits LSB first, odd parity, stop, ACK sample.
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN (adds parameter TIMEOUT_US).
module ps2_host_tx #(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int INHIBIT_US = 100
`ifdef PS2_TX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_US = 15000
`endif
) (
    input  logic           clk,
    input  logic           clrn,
    ps2_host_tx_if.slave   bus
);

    localparam int INHIBIT_CYC = CLK_FREQ / 1_000_000 * INHIBIT_US;
    localparam int CNT_W       = $clog2(INHIBIT_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_ACK,
        S_WAITIDLE
    } state_t;

    state_t           r_state;
    logic [2:0]       r_clk_sync;
    logic [1:0]       r_data_sync;
    logic             r_fall;
    logic [7:0]       r_byte;
    logic             r_par;
    logic [3:0]       r_bit;
    logic [CNT_W-1:0] r_cnt;
    logic             r_nack;
    logic             r_idle_seen;
    logic             r_tx_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_ack_err;
    logic             r_clk_oe;
    logic             r_data_oe;

    logic             w_accept;
    logic             w_bus_idle;

    assign w_accept   = (r_state == S_IDLE) && bus.tx_valid && r_tx_ready;
    assign w_bus_idle = r_clk_sync[2] && r_data_sync[1];

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TIMEOUT_CYC = CLK_FREQ / 1_000_000 * TIMEOUT_US;
    localparam int WD_W        = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] r_wd;
    logic            w_wd_expire;

    // A fall in the expiring cycle counts as device activity and wins.
    assign w_wd_expire = (r_state inside {S_REQ, S_ACK, S_WAITIDLE}) && !r_fall
                         && (r_wd == WD_W'(TIMEOUT_CYC - 1));
`endif

    // Pin synchronizers; idle-high reset values keep the first cycles free of false falls.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_clk_sync  <= 3'b111;
            r_data_sync <= 2'b11;
            r_fall      <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], bus.ps2_clk_in};
            r_data_sync <= {r_data_sync[0], bus.ps2_data_in};
            r_fall      <= r_clk_sync[2] & ~r_clk_sync[1];
        end
    end

    // Command byte and its odd-parity bit, captured at acceptance.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_byte <= bus.tx_data;
            r_par  <= ~^bus.tx_data;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state     <= S_IDLE;
            r_bit       <= '0;
            r_cnt       <= '0;
            r_nack      <= 1'b0;
            r_idle_seen <= 1'b0;
            r_tx_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ack_err   <= 1'b0;
            r_clk_oe    <= 1'b0;
            r_data_oe   <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            r_wd        <= '0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= S_INHIBIT;
                        r_busy     <= 1'b1;
                        r_tx_ready <= 1'b0;
                        r_clk_oe   <= 1'b1;
                        r_data_oe  <= 1'b0;
                        r_cnt      <= '0;
                    end
                end
                S_INHIBIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(INHIBIT_CYC - 2)) begin
                        r_data_oe <= 1'b1;
                    end
                    if (r_cnt == CNT_W'(INHIBIT_CYC - 1)) begin
                        r_state   <= S_REQ;
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b1;
                        r_bit     <= '0;
`ifdef PS2_TX_TIMEOUT_EN
                        r_wd      <= '0;
`endif
                    end
                end
                S_REQ: begin
                    if (r_fall) begin
                        r_bit <= r_bit + 1'b1;
                        if (r_bit < 4'd8) begin
                            r_data_oe <= ~r_byte[r_bit[2:0]];
                        end else if (r_bit == 4'd8) begin
                            r_data_oe <= ~r_par;
                        end else begin
                            r_data_oe <= 1'b0;
                            r_state   <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    if (r_fall) begin
                        r_nack      <= r_data_sync[1];
                        r_idle_seen <= 1'b0;
                        r_state     <= S_WAITIDLE;
                    end
                end
                S_WAITIDLE: begin
                    if (w_bus_idle) begin
                        r_idle_seen <= 1'b1;
                        if (r_idle_seen) begin
                            r_state    <= S_IDLE;
                            r_busy     <= 1'b0;
                            r_tx_ready <= 1'b1;
                            r_done     <= 1'b1;
                            r_ack_err  <= r_nack;
                        end
                    end else begin
                        r_idle_seen <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_tx_ready <= 1'b1;
                    r_clk_oe   <= 1'b0;
                    r_data_oe  <= 1'b0;
                end
            endcase
`ifdef PS2_TX_TIMEOUT_EN
            if (r_state inside {S_REQ, S_ACK, S_WAITIDLE}) begin
                r_wd <= r_fall ? '0 : r_wd + 1'b1;
            end
            if (w_wd_expire) begin
                r_state    <= S_IDLE;
                r_busy     <= 1'b0;
                r_tx_ready <= 1'b1;
                r_clk_oe   <= 1'b0;
                r_data_oe  <= 1'b0;
                r_done     <= 1'b1;
                r_ack_err  <= 1'b1;
            end
`endif
        end
    end

    assign bus.tx_ready    = r_tx_ready;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.ack_err     = r_ack_err;
    assign bus.ps2_clk_oe  = r_clk_oe;
    assign bus.ps2_data_oe = r_data_oe;

endmodule
